tone_burst_ctrl: RTL and testbench
==================================

Name: tone_burst_ctrl

Overview:
Sequencer for the team's free-running sine/cosine oscillator. It holds the oscillator in reset between bursts, releases it for a programmed number of full sine periods, then forces a programmed silent gap. Periods are counted by detecting upward zero crossings on the oscillator's sin output. It gates the sin output into a registered tone stream, and sits between the control/CSR logic and the oscillator instance.

Parameters:
WIDTH, 8, oscillator sample width; matches the oscillator's WIDTH
CNT_W, 8, width of the burst period count
GAP_W, 12, width of the gap length in clock cycles
MAX_PERIOD, 1024, timeout limit in cycles between crossings; used only with TONE_TIMEOUT_EN

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request a burst; sampled only in IDLE
abort  in  1  cancel the current burst
periods  in  CNT_W  number of full sine periods per burst; latched on accepted start
gap  in  GAP_W  number of silent cycles after the burst; latched on accepted start
sin_in  in  WIDTH  signed sin sample from the oscillator
osc_rst  out  1  reset to the oscillator instance; registered
tone_out  out  WIDTH  signed gated tone; registered
tone_valid  out  1  tone_out carries a live sample
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at normal burst completion
err  out  1  one-cycle timeout pulse; tied 0 without the macro

Behaviour:
- Reset values (rst=1): state=IDLE, osc_rst=1, tone_out=0, tone_valid=0, busy=0, done=0, err=0. The period counter, gap counter, sin_prev and the latched registers are all cleared.
- Reset mid-burst returns to IDLE on the next edge. No done pulse is generated.
- States: IDLE, RUN, GAP.
- IDLE:
  - osc_rst=1.
  - If start=1 and abort=0: latch periods and gap.
    - If periods==0, stay in IDLE and pulse done on the next cycle. The oscillator is never released.
    - Otherwise go to RUN, with osc_rst=0 from the next cycle.
  - start while not in IDLE is ignored. The request is not queued.
- RUN:
  - osc_rst=0.
  - sin_prev is a register of sin_in and is cleared to 0 on entry to RUN.
  - A crossing is sin_prev<0 (signed) and sin_in>=0. Each crossing increments the period counter.
  - When the crossing that makes the count equal to the latched periods occurs:
    - If gap>0, go to GAP with osc_rst=1 on the following cycle.
    - If gap==0, go to IDLE and pulse done in that same transition cycle.
- GAP:
  - osc_rst=1 and tone_valid=0.
  - The counter counts gap cycles.
  - On the last gap cycle, go to IDLE and pulse done (one cycle).
- Tone path:
  - tone_out <= sin_in and tone_valid <= 1 in every cycle that the state is RUN (1-cycle latency).
  - Otherwise tone_out <= 0 and tone_valid <= 0.
- abort=1 in RUN or GAP: go to IDLE on the next edge. osc_rst=1 and tone_valid=0 from that edge. No done pulse.
- abort=1 with start=1 in IDLE: abort wins and start is ignored.
- Width/arithmetic rules:
  - The counters use unsigned saturating compare (count==periods). There is no wrap inside a burst because the count is checked before increment overflow.
  - The crossing compare is signed.
- done and err never assert in the same cycle.

Optional Feature:
Macro TONE_TIMEOUT_EN.
- With the macro: a cycle counter restarts at RUN entry and at each crossing. If it reaches MAX_PERIOD while in RUN, the block pulses err for one cycle, goes to IDLE with osc_rst=1, and does not pulse done. This guards against a stalled or mis-parameterised oscillator.
- Without the macro: the counter is not built and err is constant 0. RUN exits only on the period count or abort.

Test Plan:
1. Mock sin_in: square wave -5/+5 with period 8 cycles, low first. start with periods=3, gap=10 -> busy rises next cycle; done pulses exactly once, 10 cycles after the 3rd crossing; tone_valid is high only in RUN; osc_rst=0 only in RUN.
2. periods=0, gap=5, start -> no RUN entry and osc_rst stays 1; done pulses the cycle after start; busy stays 0.
3. periods=2, gap=0 with the same mock -> done pulses in the cycle of the 2nd crossing; the next cycle is IDLE with osc_rst=1.
4. Assert abort 3 cycles into GAP, then separately during RUN -> IDLE on the next edge, no done, tone_valid=0. Also check start and abort together in IDLE -> stays IDLE.
5. Raise rst mid-RUN, then pulse start while busy in a fresh burst -> reset: all outputs at reset values the next cycle. Start while busy: ignored, and the period count is unchanged.
6. Real oscillator instance (WIDTH=8, SHIFT=6), periods=2, gap=20 -> about 800 tone_valid cycles and tone_out follows sin with 1-cycle lag. With TONE_TIMEOUT_EN, MAX_PERIOD=100 and sin_in forced to +1 -> err pulses at cycle 100 of RUN and done stays 0.

Source files
------------

// File: rtl/tone_burst_ctrl.sv
// tone_burst_ctrl: releases a free-running oscillator for a programmed number of whole sine
// periods, then holds it in reset for a silent gap. Define TONE_TIMEOUT_EN to build the crossing timeout.
module tone_burst_ctrl #(
    parameter int WIDTH      = 8,
    parameter int CNT_W      = 8,
    parameter int GAP_W      = 12,
    parameter int MAX_PERIOD = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] periods,
    input  logic [GAP_W-1:0] gap,
    input  logic [WIDTH-1:0] sin_in,
    output logic             osc_rst,
    output logic [WIDTH-1:0] tone_out,
    output logic             tone_valid,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [GAP_W-1:0] gap_len_q, gap_len_d;
    logic [GAP_W-1:0] gcnt_q, gcnt_d;
    logic [WIDTH-1:0] sin_prev_q, sin_prev_d;
    logic             osc_rst_q, osc_rst_d;
    logic [WIDTH-1:0] tone_q, tone_d;
    logic             tone_valid_q, tone_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             crossing_s;
    logic             timeout_s;
    logic [CNT_W:0]   pcnt_inc_s;
    logic [GAP_W:0]   gcnt_inc_s;

    if (MAX_PERIOD < 1) begin : g_bad_max_period
        $error("MAX_PERIOD must be at least 1");
    end

    // Upward zero crossing: previous sample negative, current sample non-negative (sign bits).
    assign crossing_s = (state_q == S_RUN) && sin_prev_q[WIDTH-1] && !sin_in[WIDTH-1];
    assign pcnt_inc_s = {1'b0, pcnt_q} + {{CNT_W{1'b0}}, 1'b1};
    assign gcnt_inc_s = {1'b0, gcnt_q} + {{GAP_W{1'b0}}, 1'b1};

`ifdef TONE_TIMEOUT_EN
    localparam int TMR_W = (MAX_PERIOD > 2) ? $clog2(MAX_PERIOD) : 1;

    logic [TMR_W-1:0] tmr_q, tmr_d;

    // Cycles since RUN entry or the last crossing; held at zero outside RUN.
    always_comb begin
        if ((state_q != S_RUN) || crossing_s) begin
            tmr_d = {TMR_W{1'b0}};
        end else begin
            tmr_d = tmr_q + TMR_W'(1);
        end
    end

    assign timeout_s = (state_q == S_RUN) && !crossing_s &&
                       (tmr_q == TMR_W'(MAX_PERIOD - 1));

    // Timeout counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmr_q <= {TMR_W{1'b0}};
        end else begin
            tmr_q <= tmr_d;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state, counters and completion/error pulses.
    always_comb begin
        state_d    = state_q;
        per_d      = per_q;
        gap_len_d  = gap_len_q;
        pcnt_d     = pcnt_q;
        gcnt_d     = gcnt_q;
        sin_prev_d = sin_prev_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    per_d     = periods;
                    gap_len_d = gap;
                    if (periods == {CNT_W{1'b0}}) begin
                        done_d = 1'b1;
                    end else begin
                        state_d    = S_RUN;
                        pcnt_d     = {CNT_W{1'b0}};
                        sin_prev_d = {WIDTH{1'b0}};
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                sin_prev_d = sin_in;
                if (abort) begin
                    state_d = S_IDLE;
                end else if (crossing_s) begin
                    pcnt_d = pcnt_inc_s[CNT_W-1:0];
                    if (pcnt_inc_s == {1'b0, per_q}) begin
                        if (gap_len_q != {GAP_W{1'b0}}) begin
                            state_d = S_GAP;
                            gcnt_d  = {GAP_W{1'b0}};
                        end else begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        state_d = S_RUN;
                    end
                end else if (timeout_s) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_GAP: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (gcnt_inc_s == {1'b0, gap_len_q}) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    gcnt_d = gcnt_inc_s[GAP_W-1:0];
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs follow the next state; a sample is live only while RUN continues.
    always_comb begin
        osc_rst_d    = (state_d != S_RUN);
        busy_d       = (state_d != S_IDLE);
        tone_valid_d = (state_q == S_RUN) && (state_d == S_RUN);
        if (tone_valid_d) begin
            tone_d = sin_in;
        end else begin
            tone_d = {WIDTH{1'b0}};
        end
    end

    // State, latched configuration, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            per_q        <= {CNT_W{1'b0}};
            gap_len_q    <= {GAP_W{1'b0}};
            pcnt_q       <= {CNT_W{1'b0}};
            gcnt_q       <= {GAP_W{1'b0}};
            sin_prev_q   <= {WIDTH{1'b0}};
            osc_rst_q    <= 1'b1;
            tone_q       <= {WIDTH{1'b0}};
            tone_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            per_q        <= per_d;
            gap_len_q    <= gap_len_d;
            pcnt_q       <= pcnt_d;
            gcnt_q       <= gcnt_d;
            sin_prev_q   <= sin_prev_d;
            osc_rst_q    <= osc_rst_d;
            tone_q       <= tone_d;
            tone_valid_q <= tone_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign osc_rst    = osc_rst_q;
    assign tone_out   = tone_q;
    assign tone_valid = tone_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_tone_burst_ctrl.sv
// Bench for tone_burst_ctrl: directed square-wave bursts plus randomized traffic, all checked
// every cycle against a burst-level reference model (countdown of periods and gap cycles).
module tb_tone_burst_ctrl;
    localparam int WIDTH = 8;
    localparam int CNT_W = 8;
    localparam int GAP_W = 12;
`ifdef TONE_TIMEOUT_EN
    localparam int MAX_P = 100;
    localparam bit TO_EN = 1'b1;
`else
    localparam int MAX_P = 1024;
    localparam bit TO_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] periods;
    logic [GAP_W-1:0] gap;
    logic [WIDTH-1:0] sin_in;
    logic             osc_rst;
    logic [WIDTH-1:0] tone_out;
    logic             tone_valid;
    logic             busy;
    logic             done;
    logic             err;

    always #5 clk = ~clk;

    tone_burst_ctrl #(
        .WIDTH(WIDTH), .CNT_W(CNT_W), .GAP_W(GAP_W), .MAX_PERIOD(MAX_P)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .periods(periods), .gap(gap), .sin_in(sin_in),
        .osc_rst(osc_rst), .tone_out(tone_out), .tone_valid(tone_valid),
        .busy(busy), .done(done), .err(err)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 idle, 1 burst running, 2 silent gap.
    int               m_mode = 0;
    int               m_left;
    int               m_rem;
    int               m_since;
    int               m_per;
    int               m_gap;
    logic signed [7:0] m_prev;
    logic             e_osc, e_valid, e_busy, e_done, e_err;
    logic [7:0]       e_tone;

    int  ph;
    bit  sq_en;
    int  done_cnt, done_ph, err_cnt, err_ph, valid_cnt, busy_cnt, run_cnt;

    function automatic logic [7:0] sq(int k);
        return ((k % 8) < 4) ? 8'hFB : 8'h05;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (ph %0d, t %0t)", name, act, exp, ph, $time);
        end
    endtask

    task automatic model_step();
        int ns;
        bit xing;
        e_done = 1'b0;
        e_err  = 1'b0;
        if (rst) begin
            m_mode = 0; m_left = 0; m_rem = 0; m_since = 0; m_per = 0; m_gap = 0; m_prev = 8'sd0;
            e_osc = 1'b1; e_valid = 1'b0; e_busy = 1'b0; e_tone = 8'd0;
            return;
        end
        ns   = m_mode;
        xing = (m_mode == 1) && (m_prev < 0) && ($signed(sin_in) >= 0);
        case (m_mode)
            0: begin
                if (start && !abort) begin
                    m_per = int'(periods);
                    m_gap = int'(gap);
                    if (m_per == 0) begin
                        e_done = 1'b1;
                    end else begin
                        ns = 1; m_left = m_per; m_since = 0;
                    end
                end
            end
            1: begin
                if (abort) begin
                    ns = 0;
                end else if (xing && m_left == 1) begin
                    if (m_gap > 0) begin
                        ns = 2; m_rem = m_gap;
                    end else begin
                        ns = 0; e_done = 1'b1;
                    end
                end else if (xing) begin
                    m_left--; m_since = 0;
                end else begin
                    m_since++;
                    if (TO_EN && m_since == MAX_P) begin
                        ns = 0; e_err = 1'b1;
                    end
                end
            end
            default: begin
                if (abort) begin
                    ns = 0;
                end else if (m_rem == 1) begin
                    ns = 0; e_done = 1'b1;
                end else begin
                    m_rem--;
                end
            end
        endcase
        e_valid = (m_mode == 1) && (ns == 1);
        e_tone  = e_valid ? sin_in : 8'd0;
        if (ns == 1 && m_mode != 1) m_prev = 8'sd0;
        else if (m_mode == 1) m_prev = $signed(sin_in);
        m_mode = ns;
        e_busy = (ns != 0);
        e_osc  = (ns != 1);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        ph++;
        if (sq_en) sin_in = sq(ph);
        chk("osc_rst", int'(osc_rst), int'(e_osc));
        chk("busy", int'(busy), int'(e_busy));
        chk("done", int'(done), int'(e_done));
        chk("err", int'(err), int'(e_err));
        chk("tone_valid", int'(tone_valid), int'(e_valid));
        chk("tone_out", int'(tone_out), int'(e_tone));
        if (done) begin done_cnt++; done_ph = ph; end
        if (err) begin err_cnt++; err_ph = ph; end
        if (tone_valid) valid_cnt++;
        if (busy) busy_cnt++;
        if (!osc_rst) run_cnt++;
    endtask

    task automatic burst_start(int p, int g);
        periods = CNT_W'(p);
        gap     = GAP_W'(g);
        start   = 1'b1;
        abort   = 1'b0;
        done_cnt = 0; done_ph = -1; err_cnt = 0; err_ph = -1;
        valid_cnt = 0; busy_cnt = 0; run_cnt = 0;
        ph = -1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        periods = '0; gap = '0; sin_in = '0; sq_en = 1'b0; ph = 0;
        tick();
        tick();
        chk("reset_osc_rst", int'(osc_rst), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_tone_valid", int'(tone_valid), 0);
        rst = 1'b0;
        sq_en = 1'b1;
        tick();

        // Three periods then ten silent cycles.
        burst_start(3, 10);
        repeat (40) tick();
        chk("t1_done_count", done_cnt, 1);
        chk("t1_done_cycle", done_ph, 31);
        chk("t1_valid_cycles", valid_cnt, 20);

        // Zero periods: immediate done, oscillator never released.
        burst_start(0, 5);
        repeat (8) tick();
        chk("t2_done_count", done_cnt, 1);
        chk("t2_done_cycle", done_ph, 0);
        chk("t2_busy_cycles", busy_cnt, 0);
        chk("t2_run_cycles", run_cnt, 0);

        // No gap: done right after the second crossing.
        burst_start(2, 0);
        repeat (20) tick();
        chk("t3_done_count", done_cnt, 1);
        chk("t3_done_cycle", done_ph, 13);
        chk("t3_valid_cycles", valid_cnt, 12);

        // Abort three cycles into the gap.
        burst_start(3, 10);
        repeat (23) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4a_busy_after_abort", int'(busy), 0);
        repeat (15) tick();
        chk("t4a_done_count", done_cnt, 0);

        // Abort during the run.
        burst_start(3, 10);
        repeat (5) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4b_osc_rst_after_abort", int'(osc_rst), 1);
        chk("t4b_tone_valid_after_abort", int'(tone_valid), 0);
        repeat (30) tick();
        chk("t4b_done_count", done_cnt, 0);

        // Start and abort together in idle.
        periods = 8'd3; gap = 12'd1; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("t4c_busy", int'(busy), 0);
        tick();

        // Reset mid-run, then a start while busy that must be ignored.
        burst_start(3, 10);
        repeat (8) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rst_osc_rst", int'(osc_rst), 1);
        chk("t5_rst_busy", int'(busy), 0);
        chk("t5_rst_tone_out", int'(tone_out), 0);
        burst_start(2, 3);
        repeat (3) tick();
        periods = 8'd5; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (30) tick();
        chk("t5_done_count", done_cnt, 1);
        chk("t5_done_cycle", done_ph, 16);

`ifdef TONE_TIMEOUT_EN
        // Stalled oscillator: sin held at +1, never crosses.
        sq_en = 1'b0;
        sin_in = 8'd1;
        burst_start(1, 0);
        repeat (110) tick();
        chk("t6_err_count", err_cnt, 1);
        chk("t6_err_cycle", err_ph, 100);
        chk("t6_done_count", done_cnt, 0);
`endif

        // Randomized traffic.
        sq_en = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            start   = ($urandom_range(0, 3) == 0);
            abort   = ($urandom_range(0, 39) == 0);
            rst     = ($urandom_range(0, 299) == 0);
            periods = CNT_W'($urandom_range(0, 4));
            gap     = GAP_W'($urandom_range(0, 12));
            if ($urandom_range(0, 1) == 0) begin
                sin_in = WIDTH'($urandom_range(0, 255));
            end else begin
                sin_in = sq(i);
            end
            tick();
        end
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        repeat (20) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
